// File: rtl/sha_dma_pkg.sv
// Shared types and constants for the SHA memory DMA master.
package sha_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        FIN
    } state_t;

    localparam int unsigned READ_LATENCY = 1;

endpackage

// File: rtl/sha_dma_rd_fifo.sv
// Synchronous read-return FIFO with occupancy count and async active-low clear.
module sha_dma_rd_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sha_mem_dma_master.sv
// Avalon-MM master moving words between on-chip memory and the SHA core streams;
// one job at a time, reads throttled by FIFO credit.
module sha_mem_dma_master
    import sha_dma_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_WORDS  = 64000,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic                avm_clken,
    input  logic [DATA_W-1:0]   avm_readdata,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

    state_t             state;
    logic [ADDR_W-1:0]  cur_addr;
    logic [LEN_W-1:0]   remaining;
    logic               inflight;
    logic               done_q;
    logic               err_q;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     credit_used;
    logic [SUM_W-1:0]   end_addr;
    logic               range_bad;
    logic               rd_issue;
    logic               wr_hs;
    logic               rd_pop;
    logic               drain_empty;

    assign end_addr    = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
    assign range_bad   = end_addr > SUM_W'(MAX_WORDS);
    assign credit_used = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight);
    assign rd_issue    = (state == READ) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
    assign wr_hs       = (state == WRITE) && wr_valid;
    assign rd_valid    = (fifo_count != '0);
    assign rd_pop      = rd_valid && rd_ready;
    // Leave DRAIN as the last word is being consumed so done follows it directly.
    assign drain_empty = !inflight &&
                         ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && rd_pop));

    assign cmd_ready      = (state == IDLE);
    assign busy           = (state != IDLE);
    assign done           = done_q;
    assign err            = err_q;
    assign wr_ready       = (state == WRITE);
    assign avm_address    = cur_addr;
    assign avm_byteenable = '1;
    assign avm_chipselect = rd_issue || wr_hs;
    assign avm_write      = wr_hs;
    assign avm_writedata  = wr_data;
    assign avm_clken      = 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            inflight <= rd_issue;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (range_bad) begin
                            err_q <= 1'b1;
                        end else if (cmd_len == '0) begin
                            state  <= FIN;
                            done_q <= 1'b1;
                        end else begin
                            cur_addr  <= cmd_addr;
                            remaining <= cmd_len;
                            state     <= cmd_write ? WRITE : READ;
                        end
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        state  <= FIN;
                        done_q <= 1'b1;
                    end
                end
                WRITE: begin
                    if (wr_hs) begin
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            state  <= FIN;
                            done_q <= 1'b1;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    sha_dma_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_rd_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (avm_readdata),
        .pop       (rd_pop),
        .head      (rd_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_sha_mem_dma_master.sv
// Scoreboard bench for sha_mem_dma_master: memory slave model, stream drivers,
// queued expectations checked by a negedge monitor.
module tb_sha_mem_dma_master;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;
    localparam int MAX_WORDS  = 64000;
    localparam int LEN_W      = 16;
    localparam int FIFO_DEPTH = 4;

    logic              clk;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_chipselect;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_clken;
    logic [31:0]       avm_readdata;
    logic [31:0]       rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [31:0]       wr_data;
    logic              wr_valid;
    logic              wr_ready;

    sha_mem_dma_master #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_WORDS  (MAX_WORDS),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .avm_address    (avm_address),
        .avm_byteenable (avm_byteenable),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_clken      (avm_clken),
        .avm_readdata   (avm_readdata),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .wr_data        (wr_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory slave: read data valid the cycle after the access.
    logic [31:0] mem     [MAX_WORDS];
    logic [31:0] ref_mem [MAX_WORDS];
    always @(posedge clk) begin
        if (avm_chipselect) begin
            if (avm_write) mem[avm_address] <= avm_writedata;
            else           avm_readdata     <= mem[avm_address];
        end
    end

    typedef struct { logic [15:0] a; logic [31:0] d; } wr_t;
    typedef struct { bit is_err; int ecyc; bit chk_wr; } ev_t;

    logic [31:0] exp_rd_q[$];
    logic [15:0] exp_addr_q[$];
    wr_t         exp_wr_q[$];
    ev_t         exp_ev_q[$];
    logic [31:0] wr_src_q[$];
    int          pop_cyc[$];

    int checks = 0;
    int failures = 0;
    int t0 = 0;
    int rd_strobes, wr_strobes, rd_pops, rd_early, last_wr_cyc, ev_seen;
    int rd_mode = 0;
    bit wr_rand = 0;
    bit hold_cmd = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc - t0);
        end
    endfunction

    function automatic void extra(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got 0x%0h required nothing", name, act);
    endfunction

    // Monitor: every DUT output event pops and checks against the queued expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rd_valid && rd_ready) begin
                pop_cyc.push_back(cyc - t0);
                rd_pops++;
                if (exp_rd_q.size() == 0) extra("rd_extra", rd_data);
                else chk("rd_data", rd_data, exp_rd_q.pop_front());
            end
            if (avm_chipselect && !avm_write) begin
                rd_strobes++;
                if (cyc - t0 <= 10) rd_early++;
                if (exp_addr_q.size() == 0) extra("rd_strobe_extra", avm_address);
                else chk("rd_addr", avm_address, exp_addr_q.pop_front());
            end
            if (avm_chipselect && avm_write) begin
                wr_t w;
                wr_strobes++;
                last_wr_cyc = cyc;
                chk("wr_strobe_on_hs", wr_valid && wr_ready, 1);
                if (exp_wr_q.size() == 0) extra("wr_strobe_extra", avm_address);
                else begin
                    w = exp_wr_q.pop_front();
                    chk("wr_addr", avm_address, w.a);
                    chk("wr_data", avm_writedata, w.d);
                end
            end
            if (done || err) begin
                ev_t e;
                ev_seen++;
                if (exp_ev_q.size() == 0) extra("event_extra", {done, err});
                else begin
                    e = exp_ev_q.pop_front();
                    chk("event_kind", {done, err}, e.is_err ? 2'b01 : 2'b10);
                    if (e.ecyc >= 0) chk("event_cycle", cyc - t0, e.ecyc);
                    if (e.chk_wr) chk("done_after_last_wr", cyc - last_wr_cyc, 1);
                end
            end
        end
    end

    initial begin
        rd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rd_mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = $urandom_range(0, 1) == 1;
                default: rd_ready = !((cyc - t0) >= 3 && (cyc - t0) <= 10);
            endcase
        end
    end

    initial begin
        wr_valid = 1'b0;
        wr_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (wr_src_q.size() != 0 && (!wr_rand || $urandom_range(0, 1) == 1)) begin
                wr_valid = 1'b1;
                wr_data  = wr_src_q[0];
            end else begin
                wr_valid = 1'b0;
                wr_data  = $urandom;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && wr_valid && wr_ready && wr_src_q.size() != 0) void'(wr_src_q.pop_front());
        end
    end

    task automatic wait_event(input int base);
        int n = 0;
        while (ev_seen == base && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("job_completes", ev_seen - base, 1);
    endtask

    task automatic job(input bit w, input int addr, input int len, input int ecyc, input bit wait_done);
        ev_t e;
        int  base;
        bit  bad;
        bad = (addr + len) > MAX_WORDS;
        e.is_err = bad;
        e.ecyc   = (bad || len == 0) ? 1 : ecyc;
        e.chk_wr = w && !bad && len > 0;
        if (!bad) begin
            for (int i = 0; i < len; i++) begin
                if (w) begin
                    wr_t x;
                    x.a = 16'(addr + i);
                    x.d = $urandom;
                    ref_mem[addr + i] = x.d;
                    exp_wr_q.push_back(x);
                    wr_src_q.push_back(x.d);
                end else begin
                    exp_rd_q.push_back(ref_mem[addr + i]);
                    exp_addr_q.push_back(16'(addr + i));
                end
            end
        end
        exp_ev_q.push_back(e);
        base = ev_seen;
        @(posedge clk);
        #1;
        rd_strobes = 0; wr_strobes = 0; rd_pops = 0; rd_early = 0;
        pop_cyc.delete();
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = 16'(addr);
        cmd_len   = 16'(len);
        t0 = cyc;
        @(posedge clk);
        #1;
        if (!hold_cmd) cmd_valid = 1'b0;
        if (wait_done) begin
            wait_event(base);
            if (hold_cmd) begin
                #1;
                cmd_valid = 1'b0;
            end
            chk("rd_queue_drained", exp_rd_q.size(), 0);
            chk("wr_queue_drained", exp_wr_q.size(), 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_cs"}, avm_chipselect, 0);
        chk({tag, "_write"}, avm_write, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        rd_strobes = 0; wr_strobes = 0; rd_pops = 0; rd_early = 0; last_wr_cyc = 0; ev_seen = 0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            mem[i]     = 32'(i);
            ref_mem[i] = 32'(i);
        end
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        chk("byteenable", avm_byteenable, 4'hF);
        chk("clken", avm_clken, 1);
        reset_n = 1'b1;

        // Streaming read, rd_ready held high.
        rd_mode = 0;
        job(0, 16'h0100, 16, 19, 1);
        chk("t1_pops", pop_cyc.size(), 16);
        for (int i = 0; i < pop_cyc.size(); i++) chk("t1_pop_cycle", pop_cyc[i], 3 + i);
        chk("t1_rd_strobes", rd_strobes, 16);

        // Consumer stall: credit limits outstanding reads.
        rd_mode = 2;
        job(0, 16'h0040, 8, -1, 1);
        chk("t2_credit_limit", rd_early <= 4, 1);
        chk("t2_pops", rd_pops, 8);

        // Write-back with a toggling producer.
        rd_mode = 0;
        wr_rand = 1;
        job(1, 16'h2000, 8, -1, 1);
        chk("t3_wr_strobes", wr_strobes, 8);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) chk("t3_mem", mem[16'h2000 + i], ref_mem[16'h2000 + i]);

        // Range error and zero length: pulse on cycle 1, no access.
        job(0, 63990, 16, 1, 1);
        chk("err_no_access", rd_strobes + wr_strobes, 0);
        job(1, 100, 0, 1, 1);
        chk("len0_no_access", rd_strobes + wr_strobes, 0);
        job(0, 63984, 16, -1, 1);
        chk("edge_range_rd", rd_strobes, 16);

        // Reset in the middle of a read job.
        job(0, 16'h0300, 16, -1, 0);
        n = 0;
        while (rd_pops < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_5_words", rd_pops >= 5, 1);
        #2;
        reset_n = 1'b0;
        exp_rd_q.delete(); exp_addr_q.delete(); exp_wr_q.delete(); exp_ev_q.delete(); wr_src_q.delete();
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset_hold");
        reset_n = 1'b1;
        job(0, 16'h0500, 2, -1, 1);
        chk("t5_after_reset_pops", rd_pops, 2);

        // cmd_valid held during the job is not taken until idle.
        hold_cmd = 1;
        job(0, 16'h0600, 4, -1, 1);
        hold_cmd = 0;
        n = ev_seen;
        repeat (6) @(posedge clk);
        chk("hold_rd_strobes", rd_strobes, 4);
        chk("hold_no_extra_event", ev_seen - n, 0);

        // Randomised jobs with random back-pressure.
        rd_mode = 1;
        for (int k = 0; k < 8; k++) begin
            int len;
            int addr;
            bit w;
            len  = $urandom_range(1, 20);
            addr = $urandom_range(0, MAX_WORDS - len);
            w    = $urandom_range(0, 1) == 1;
            job(w, addr, len, -1, 1);
            chk(w ? "rand_wr_strobes" : "rand_rd_strobes", w ? wr_strobes : rd_strobes, len);
        end
        @(posedge clk);
        #1;
        for (int i = 16'h2000; i < 16'h2008; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
